// File: rtl/display_pkg.sv
// display_pkg: slot descriptor layout, default 640x480 timing and colour types
// shared by the sprite display pipeline and its bench.
package display_pkg;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;

  localparam int DEF_TYPE_W = 3;
  localparam int DEF_X_W    = 10;
  localparam int DEF_Y_W    = 9;
  localparam int TYPE_LSB   = 0;
  localparam int SCALE_W    = 2;
  localparam int MIRROR_W   = 1;
  localparam int COLOR_W    = 12;

  typedef logic [COLOR_W-1:0] rgb_t;

  typedef struct packed {
    rgb_t                  color;
    logic [MIRROR_W-1:0]   mirror;
    logic [SCALE_W-1:0]    scale;
    logic [DEF_Y_W-1:0]    y;
    logic [DEF_X_W-1:0]    x;
    logic [DEF_TYPE_W-1:0] ty;
  } slot_t;
endpackage

// File: rtl/display_timing.sv
// display_timing: VGA h/v counters, raw syncs, active flag,
// pixel coordinates and the once-per-frame shadow latch strobe.
module display_timing
  import display_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W
) (
  input  logic           clock,
  input  logic           reset,
  output logic [X_W-1:0] px,
  output logic [Y_W-1:0] py,
  output logic           hsync,
  output logic           vsync,
  output logic           active,
  output logic           latch
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  localparam int V_LATCH = V_START + V_ACTIVE;

  logic [HC_W-1:0] hcount;
  logic [VC_W-1:0] vcount;
  logic            h_end;
  logic            v_end;

  assign h_end = hcount == HC_W'(H_TOTAL - 1);
  assign v_end = vcount == VC_W'(V_TOTAL - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_end ? '0 : hcount + 1'b1;
      if (h_end)
        vcount <= v_end ? '0 : vcount + 1'b1;
    end
  end

  assign hsync  = hcount >= HC_W'(H_SYNC);
  assign vsync  = vcount >= VC_W'(V_SYNC);
  assign active = (hcount >= HC_W'(H_START))
               && (hcount < HC_W'(H_START + H_ACTIVE))
               && (vcount >= VC_W'(V_START))
               && (vcount < VC_W'(V_START + V_ACTIVE));
  assign latch  = (hcount == '0) && (vcount == VC_W'(V_LATCH));

  // Outside the active window these wrap; the active flag masks them.
  assign px = X_W'(hcount - HC_W'(H_START));
  assign py = Y_W'(vcount - VC_W'(V_START));
endmodule

// File: rtl/sprite_display.sv
// sprite_display: 3-stage VGA sprite compositor over a background colour.
// Define SPRITE_DISPLAY_TRANSPARENT_EN to make texel 0 transparent.
module sprite_display
  import display_pkg::*;
#(
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   SLOTS     = 8,
  parameter int   IMG_COUNT = 4,
  parameter int   IMG_W     = 16,
  parameter int   IMG_H     = 16,
  parameter int   TYPE_W    = DEF_TYPE_W,
  parameter int   X_W       = DEF_X_W,
  parameter int   Y_W       = DEF_Y_W,
  parameter rgb_t BG_COLOR  = 12'hFFF,
  localparam int  SLOT_W    = TYPE_W + X_W + Y_W
                            + SCALE_W + MIRROR_W + COLOR_W
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [IMG_COUNT*IMG_W*IMG_H-1:0] image,
  input  logic [SLOTS*SLOT_W-1:0]          gamedata,
  output logic [13:0]                      vga,
  output logic                             frame_start,
  output logic                             active
);
  localparam int IDX_W   = $clog2(IMG_COUNT * IMG_W * IMG_H);
  localparam int U_W     = $clog2(IMG_W);
  localparam int V_W     = $clog2(IMG_H);
  localparam int X_LSB   = TYPE_LSB + TYPE_W;
  localparam int Y_LSB   = X_LSB + X_W;
  localparam int SC_LSB  = Y_LSB + Y_W;
  localparam int MR_LSB  = SC_LSB + SCALE_W;
  localparam int COL_LSB = MR_LSB + MIRROR_W;

  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;
  logic           hs0, vs0, act0, latch;

  display_timing #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT),
    .X_W(X_W), .Y_W(Y_W)
  ) u_timing (
    .clock(clock), .reset(reset),
    .px(px), .py(py),
    .hsync(hs0), .vsync(vs0),
    .active(act0), .latch(latch)
  );

  logic [SLOTS*SLOT_W-1:0] shadow;

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow      <= '0;
      frame_start <= 1'b0;
    end else begin
      if (latch)
        shadow <= gamedata;
      frame_start <= latch;
    end
  end

  logic [SLOTS-1:0] hit_c;
  logic [IDX_W-1:0] idx_c [SLOTS];

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic [TYPE_W-1:0]  ty;
    logic [X_W-1:0]     sx;
    logic [Y_W-1:0]     sy;
    logic [SCALE_W-1:0] sc;
    logic               mr;
    logic [X_W:0]       x_end;
    logic [Y_W:0]       y_end;
    logic [U_W-1:0]     u_raw, u;
    logic [V_W-1:0]     v;

    assign ty = shadow[i*SLOT_W + TYPE_LSB +: TYPE_W];
    assign sx = shadow[i*SLOT_W + X_LSB +: X_W];
    assign sy = shadow[i*SLOT_W + Y_LSB +: Y_W];
    assign sc = shadow[i*SLOT_W + SC_LSB +: SCALE_W];
    assign mr = shadow[i*SLOT_W + MR_LSB];

    // One extra bit keeps right/bottom edges from wrapping to 0.
    assign x_end = {1'b0, sx} + ((X_W+1)'(IMG_W) << sc);
    assign y_end = {1'b0, sy} + ((Y_W+1)'(IMG_H) << sc);

    assign u_raw = U_W'((px - sx) >> sc);
    assign u     = mr ? U_W'(IMG_W - 1) - u_raw : u_raw;
    assign v     = V_W'((py - sy) >> sc);

    assign hit_c[i] = (ty != '0) && (32'(ty) <= IMG_COUNT)
                   && (px >= sx) && ({1'b0, px} < x_end)
                   && (py >= sy) && ({1'b0, py} < y_end);
    assign idx_c[i] = IDX_W'(((32'(ty) - 1) * IMG_H + 32'(v))
                             * IMG_W + 32'(u));
  end

  logic [SLOTS-1:0] hit_q;
  logic [IDX_W-1:0] idx_q [SLOTS];
  logic             hs1, vs1, act1;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q <= '0;
      idx_q <= '{default: '0};
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      act1  <= 1'b0;
    end else begin
      hit_q <= hit_c;
      idx_q <= idx_c;
      hs1   <= hs0;
      vs1   <= vs0;
      act1  <= act0;
    end
  end

  // Colour is read straight from the shadow: it only changes in blanking.
  rgb_t rgb_c;

  always_comb begin
    rgb_c = BG_COLOR;
    for (int i = SLOTS - 1; i >= 0; i--) begin
`ifdef SPRITE_DISPLAY_TRANSPARENT_EN
      if (hit_q[i] && image[idx_q[i]])
        rgb_c = shadow[i*SLOT_W + COL_LSB +: COLOR_W];
`else
      if (hit_q[i])
        rgb_c = image[idx_q[i]]
              ? shadow[i*SLOT_W + COL_LSB +: COLOR_W]
              : BG_COLOR;
`endif
    end
    if (!act1)
      rgb_c = '0;
  end

  rgb_t rgb2;
  logic hs2, vs2, act2;

  always_ff @(posedge clock) begin
    if (reset) begin
      rgb2   <= '0;
      hs2    <= 1'b0;
      vs2    <= 1'b0;
      act2   <= 1'b0;
      vga    <= '0;
      active <= 1'b0;
    end else begin
      rgb2   <= rgb_c;
      hs2    <= hs1;
      vs2    <= vs1;
      act2   <= act1;
      vga    <= {vs2, hs2, rgb2};
      active <= act2;
    end
  end
endmodule

// File: tb/tb_sprite_display.sv
// tb_sprite_display: scoreboard bench on a shrunken 52x36 raster so many
// frames fit in a short run; expected pixels are queued by raster index.
module tb_sprite_display;
  import display_pkg::*;

  localparam int HS = 4, HB = 4, HA = 40, HF = 4;
  localparam int VS = 2, VB = 2, VA = 30, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;
  localparam int FS_PHASE = (VS + VB + VA) * HT + 1;
  localparam int NSLOT = 8;
  localparam int SW = $bits(slot_t);
`ifdef SPRITE_DISPLAY_TRANSPARENT_EN
  localparam logic [11:0] HOLE = 12'h00F;
`else
  localparam logic [11:0] HOLE = 12'hFFF;
`endif

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [1023:0]         image;
  logic [NSLOT*SW-1:0]   gamedata;
  logic [13:0]           vga;
  logic                  frame_start;
  logic                  active;

  sprite_display #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .SLOTS(NSLOT), .IMG_COUNT(4), .IMG_W(16), .IMG_H(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .image(image),
    .gamedata(gamedata),
    .vga(vga),
    .frame_start(frame_start),
    .active(active)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          k;
    logic [13:0] vga;
    logic        act;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails = 0;
  int   e = 0;

  always @(posedge clock)
    if (reset) e <= 0;
    else       e <= e + 1;

  task automatic expect_hv(int f, int h, int v, logic [11:0] rgb);
    exp_t x;
    bit   a;
    int   i;
    a = (h >= HS + HB) && (h < HS + HB + HA)
     && (v >= VS + VB) && (v < VS + VB + VA);
    x.k   = f * FRAME + v * HT + h;
    x.act = a;
    x.vga = {(v >= VS) ? 1'b1 : 1'b0, (h >= HS) ? 1'b1 : 1'b0,
             a ? rgb : 12'h000};
    i = 0;
    while (i < q.size() && q[i].k <= x.k) i++;
    q.insert(i, x);
  endtask

  task automatic expect_px(int f, int px, int py, logic [11:0] rgb);
    expect_hv(f, px + HS + HB, py + VS + VB, rgb);
  endtask

  always @(negedge clock) begin
    int cur;
    bit efs;
    if (!reset) begin
      efs = (e % FRAME) == FS_PHASE;
      if (frame_start || efs) begin
        checks++;
        if (frame_start !== efs) begin
          fails++;
          $display("FAIL frame_start cycle %0d: got %b want %b",
                   e, frame_start, efs);
        end
      end
      cur = e - 3;
      while (q.size() > 0 && q[0].k < cur) begin
        checks++;
        fails++;
        $display("FAIL pixel f=%0d h=%0d v=%0d never compared",
                 q[0].k / FRAME, q[0].k % HT, (q[0].k % FRAME) / HT);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].k == cur) begin
        checks++;
        if (vga !== q[0].vga || active !== q[0].act) begin
          fails++;
          $display("FAIL pixel f=%0d h=%0d v=%0d: vga=%h act=%b want vga=%h act=%b",
                   cur / FRAME, cur % HT, (cur % FRAME) / HT,
                   vga, active, q[0].vga, q[0].act);
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic check_now(string name, logic [13:0] got, logic [13:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic slot_t mk(int ty, int x, int y, int sc, int mr,
                               logic [11:0] col);
    slot_t s;
    s.ty     = 3'(ty);
    s.x      = 10'(x);
    s.y      = 9'(y);
    s.scale  = 2'(sc);
    s.mirror = 1'(mr);
    s.color  = col;
    return s;
  endfunction

  task automatic set_slot(int i, slot_t s);
    gamedata[i*SW +: SW] = s;
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_start && n < 2 * FRAME);
    if (!frame_start) begin
      checks++;
      fails++;
      $display("FAIL frame_start wait: got no pulse want one within %0d", 2 * FRAME);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 2 * FRAME) begin
      @(negedge clock);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    image = '0;
    for (int b = 0; b < 256; b++) begin
      image[b]       = 1'b1;
      image[768 + b] = 1'b1;
    end
    image[256] = 1'b1;
    for (int v = 0; v < 16; v++)
      for (int u = 0; u < 16; u++)
        image[512 + v*16 + u] = ((u ^ v) & 1) == 0;

    gamedata = '0;
    set_slot(0, mk(1, 10, 5, 0, 0, 12'h0F0));

    expect_hv(0, 0, 0, 12'h000);
    expect_hv(0, 3, 1, 12'h000);
    expect_hv(0, 4, 1, 12'h000);
    expect_hv(0, 3, 2, 12'h000);
    expect_hv(0, 7, 4, 12'h000);
    expect_hv(0, 8, 4, 12'hFFF);
    expect_hv(0, 47, 33, 12'hFFF);
    expect_hv(0, 48, 33, 12'h000);
    expect_hv(0, 8, 34, 12'h000);
    expect_px(0, 10, 5, 12'hFFF);

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_now("pipeline_zero_after_reset", vga, 14'd0);

    for (int f = 1; f <= 8; f++) begin
      wait_fs();
      case (f)
        1: begin
          expect_px(1, 10, 5, 12'h0F0);
          expect_px(1, 25, 20, 12'h0F0);
          expect_px(1, 9, 5, 12'hFFF);
          expect_px(1, 26, 5, 12'hFFF);
          expect_px(1, 10, 21, 12'hFFF);
          gamedata = '0;
          set_slot(0, mk(1, 20, 10, 0, 0, 12'hF00));
          set_slot(2, mk(1, 20, 10, 0, 0, 12'h00F));
        end
        2: begin
          expect_px(2, 20, 10, 12'hF00);
          expect_px(2, 35, 25, 12'hF00);
          expect_px(2, 36, 25, 12'hFFF);
          gamedata = '0;
          set_slot(1, mk(5, 20, 10, 0, 0, 12'h0FF));
          set_slot(2, mk(1, 20, 10, 0, 0, 12'h00F));
          set_slot(3, mk(4, 0, 25, 0, 0, 12'h888));
        end
        3: begin
          expect_px(3, 20, 10, 12'h00F);
          expect_px(3, 0, 25, 12'h888);
          expect_px(3, 15, 29, 12'h888);
          gamedata = '0;
          set_slot(0, mk(2, 0, 0, 1, 1, 12'hF0F));
        end
        4: begin
          expect_px(4, 0, 0, 12'hFFF);
          expect_px(4, 29, 0, 12'hFFF);
          expect_px(4, 30, 0, 12'hF0F);
          expect_px(4, 31, 1, 12'hF0F);
          expect_px(4, 32, 0, 12'hFFF);
          expect_px(4, 30, 2, 12'hFFF);
          gamedata = '0;
          set_slot(0, mk(2, 0, 0, 1, 0, 12'hF0F));
        end
        5: begin
          expect_px(5, 0, 0, 12'hF0F);
          expect_px(5, 1, 1, 12'hF0F);
          expect_px(5, 2, 0, 12'hFFF);
          expect_px(5, 30, 0, 12'hFFF);
          gamedata = '0;
          set_slot(0, mk(1, 30, 3, 0, 0, 12'h0F0));
          set_slot(1, mk(1, 1020, 3, 0, 0, 12'h00F));
        end
        6: begin
          expect_px(6, 0, 3, 12'hFFF);
          expect_px(6, 5, 3, 12'hFFF);
          expect_px(6, 30, 3, 12'h0F0);
          expect_px(6, 39, 3, 12'h0F0);
          expect_px(6, 30, 15, 12'h0F0);
          expect_px(6, 30, 18, 12'h0F0);
          repeat (FRAME - FS_PHASE + 14 * HT) @(negedge clock);
          gamedata = '0;
        end
        7: begin
          expect_px(7, 30, 3, 12'hFFF);
          gamedata = '0;
          set_slot(0, mk(3, 0, 0, 0, 0, 12'hF00));
          set_slot(1, mk(4, 0, 0, 0, 0, 12'h00F));
        end
        default: begin
          expect_px(8, 0, 0, 12'hF00);
          expect_px(8, 1, 0, HOLE);
          expect_px(8, 1, 1, 12'hF00);
          expect_px(8, 16, 0, 12'hFFF);
        end
      endcase
    end
    drain();

    gamedata = '0;
    set_slot(0, mk(1, 0, 0, 0, 0, 12'h0F0));
    for (int n = 0; n < HT && (e % HT) != 20; n++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_now("reset_vga", vga, 14'd0);
    check_now("reset_active", {13'd0, active}, 14'd0);
    check_now("reset_frame_start", {13'd0, frame_start}, 14'd0);
    expect_hv(0, 0, 0, 12'h000);
    expect_px(0, 0, 0, 12'hFFF);
    reset = 1'b0;
    wait_fs();
    expect_px(1, 0, 0, 12'h0F0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
